keypad_debounce_encoder: RTL and testbench
==========================================

// Module: keypad_debounce_encoder
// PURPOSE
//  Parametrised successor to the one-hot button encoder: synchronises NUM_KEYS raw button lines,
//  debounces press and release, and emits a binary key code with a single-cycle key_valid strobe.
//  Rejects multi-key presses. Sits between the keypad pins and the password-entry FSM.
// PARAMETERS
//  NUM_KEYS      16    number of button inputs, 2..64
//  CODE_W        4     key_code width, must equal $clog2(NUM_KEYS)
//  DEBOUNCE_CYC  1000  consecutive identical synced samples needed to accept a press or release, >=2
//  REPEAT_CYC    50000 autorepeat period in HELD, >=DEBOUNCE_CYC (used only with KEYPAD_REPEAT_EN)
// PORTS
//  clk            in   1         system clock, rising edge
//  rst            in   1         asynchronous, active-high reset
//  buttons        in   NUM_KEYS  raw async button lines, bit i = key i pressed
//  key_code       out  CODE_W    index of the last accepted key, held until the next accept
//  key_valid      out  1         1-cycle strobe: key_code newly valid
//  key_held       out  1         high while the accepted key stays pressed (state HELD)
//  multi_key_err  out  1         1-cycle strobe: more than one key is down
// BEHAVIOUR
//  - Reset: all outputs 0, sync flops 0, counter 0, state IDLE. Takes effect immediately.
//  - Sync: 2-flop synchroniser per bit gives syn[NUM_KEYS-1:0]. All decisions use syn.
//  - Counter cnt is wide enough for max(DEBOUNCE_CYC, REPEAT_CYC). It never wraps; it saturates at its target.
//  - FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
//  - IDLE, syn==0: stay.
//    IDLE, syn one-hot: cand<=syn, cnt<=1, go to PRESS_DB.
//    IDLE, >1 bit set: multi_key_err pulse, cnt<=0, go to RELEASE_DB.
//  - PRESS_DB, syn!=cand: go to IDLE (bounce discarded, no output).
//    PRESS_DB, syn==cand: cnt++.
//    Reaching cnt==DEBOUNCE_CYC registers key_code<=index(cand) and key_valid<=1 for one cycle,
//    then goes to HELD with cnt<=0.
//  - Latency: key_valid rises on the (DEBOUNCE_CYC+2)th rising edge after buttons become stable.
//  - HELD: key_held=1.
//    HELD, syn==cand: stay.
//    HELD, syn!=cand: go to RELEASE_DB, cnt<=0.
//    If syn contains cand plus any other bit, also pulse multi_key_err once.
//  - RELEASE_DB: cnt++ while syn==0; any nonzero syn sets cnt<=0.
//    Reaching cnt==DEBOUNCE_CYC goes to IDLE. A new key cannot be accepted until full release.
//  - key_held is 0 in every state except HELD. Outputs are registered; there are no combinational paths from buttons.
//  - Index encoding: bit i -> code i. Lowest code 0, highest NUM_KEYS-1.
//  - Simultaneous: two keys pressed on the same sync edge -> multi_key_err, no key_valid.
//  - Reset mid-press: state returns to IDLE. A key still down after reset is debounced anew and strobed once.
// CONFIGURATION
//  - KEYPAD_REPEAT_EN defined: in HELD, cnt counts cycles.
//    At cnt==REPEAT_CYC, key_valid pulses again with an unchanged key_code, and cnt<=0.
//    This repeats every REPEAT_CYC cycles while the key is held.
//  - KEYPAD_REPEAT_EN undefined: exactly one key_valid per press. REPEAT_CYC is unused, and cnt is idle in HELD.
// TESTING  (NUM_KEYS=16, DEBOUNCE_CYC=4, REPEAT_CYC=8 unless noted)
//  1 rst=1 with buttons=16'h0200 -> all outputs 0.
//    Release rst with the key still down -> key_valid 1 cycle on the 6th edge, key_code=9.
//  2 buttons=16'h0008 toggling 0/1 every 2 cycles for 20 cycles, then held -> no strobe during bounce.
//    Exactly one key_valid after 6 stable edges, key_code=3.
//  3 buttons=16'h0011 from idle -> multi_key_err 1 cycle, no key_valid.
//    Release to 0 for 4 cycles, then 16'h8000 -> key_valid, key_code=15.
//  4 Hold 16'h0004 for 40 cycles -> key_held=1 throughout, one key_valid, code 2.
//    With KEYPAD_REPEAT_EN: extra key_valid every 8 cycles.
//  5 While holding key 2, add key 5 (16'h0024) -> one multi_key_err, key_held=0.
//    No new key_valid until 4 cycles of all-released.
//  6 Assert rst for 1 cycle mid-PRESS_DB (cnt=2) -> outputs 0 immediately.
//    Debounce restarts from 0: key_valid 6 edges after rst is released.

Source files
------------

// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: 2-flop synchroniser, press/release debounce, one-hot to binary key code.
// Optional autorepeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_debounce_encoder #(
   parameter int NUM_KEYS     = 16,
   parameter int CODE_W       = 4,
   parameter int DEBOUNCE_CYC = 1000,
   parameter int REPEAT_CYC   = 50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] buttons,
   output logic [CODE_W-1:0]   key_code,
   output logic                key_valid,
   output logic                key_held,
   output logic                multi_key_err
);

   localparam int MAX_CYC = (DEBOUNCE_CYC > REPEAT_CYC) ? DEBOUNCE_CYC : REPEAT_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYC - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESS_DB,
      S_HELD,
      S_RELEASE_DB
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_KEYS-1:0] sync1_q, syn_q;
   logic [NUM_KEYS-1:0] cand_q, cand_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CODE_W-1:0]   key_code_q, key_code_d;
   logic                key_valid_q, key_valid_d;
   logic                key_held_q, key_held_d;
   logic                err_q, err_d;
   logic                syn_onehot;

   function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   function automatic logic [CODE_W-1:0] onehot_index(input logic [NUM_KEYS-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (v[i]) idx = CODE_W'(i);
      end
      return idx;
   endfunction

   assign syn_onehot = is_onehot(syn_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= '0;
         syn_q       <= '0;
         state_q     <= S_IDLE;
         cand_q      <= '0;
         cnt_q       <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         sync1_q     <= buttons;
         syn_q       <= sync1_q;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         err_q       <= err_d;
      end
   end

   // Counter compares use >= so a corrupted count still terminates instead of wrapping.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (syn_onehot) begin
               cand_d  = syn_q;
               cnt_d   = CNT_ONE;
               state_d = S_PRESS_DB;
            end else if (syn_q != '0) begin
               cnt_d   = '0;
               state_d = S_RELEASE_DB;
            end
         end
         S_PRESS_DB: begin
            if (syn_q != cand_q) begin
               state_d = S_IDLE;
            end else if (cnt_q >= DB_LAST) begin
               cnt_d   = '0;
               state_d = S_HELD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HELD: begin
            if (syn_q != cand_q) begin
               cnt_d   = '0;
               state_d = S_RELEASE_DB;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (cnt_q >= RP_LAST) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_RELEASE_DB: begin
            if (syn_q != '0) begin
               cnt_d = '0;
            end else if (cnt_q >= DB_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      err_d       = 1'b0;
      key_held_d  = (state_d == S_HELD);
      case (state_q)
         S_IDLE: begin
            if (syn_q != '0 && !syn_onehot) err_d = 1'b1;
         end
         S_PRESS_DB: begin
            if (syn_q == cand_q && cnt_q >= DB_LAST) begin
               key_valid_d = 1'b1;
               key_code_d  = onehot_index(cand_q);
            end
         end
         S_HELD: begin
            if (syn_q != cand_q) begin
               if ((syn_q & cand_q) != '0) err_d = 1'b1;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (cnt_q >= RP_LAST) begin
               key_valid_d = 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   assign key_code      = key_code_q;
   assign key_valid     = key_valid_q;
   assign key_held      = key_held_q;
   assign multi_key_err = err_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Bench for keypad_debounce_encoder: directed corner sequences, a segment table, and random
// stimulus, all compared cycle by cycle against a behavioural model of the keypad rules.
module tb_keypad_debounce_encoder;
   localparam int NK = 16;
   localparam int CW = 4;
   localparam int DB = 4;
   localparam int RP = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] buttons = '0;
   logic [CW-1:0] key_code;
   logic          key_valid, key_held, multi_key_err;

   always #5 clk = ~clk;

   keypad_debounce_encoder #(
      .NUM_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYC(DB), .REPEAT_CYC(RP)
   ) dut (
      .clk(clk), .rst(rst), .buttons(buttons), .key_code(key_code),
      .key_valid(key_valid), .key_held(key_held), .multi_key_err(multi_key_err)
   );

   int checks = 0;
   int failures = 0;
   int n_valid = 0;
   int n_err = 0;

   // Behavioural model: mode 0 idle, 1 press debounce, 2 held, 3 release debounce.
   logic [NK-1:0] m_s1, m_syn, m_cand;
   int            m_mode, m_cnt;
   logic [CW-1:0] m_code;
   logic          m_valid, m_err;

   typedef struct {
      logic [NK-1:0] btn;
      int            cyc;
      int            nv;
      int            ne;
      logic [CW-1:0] code;
      logic          held;
   } seg_t;
   seg_t segs[14];

   function automatic int idx_of(input logic [NK-1:0] v);
      for (int i = 0; i < NK; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_syn = '0; m_cand = '0; m_mode = 0; m_cnt = 0;
      m_code = '0; m_valid = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic [NK-1:0] b);
      m_valid = 1'b0;
      m_err   = 1'b0;
      case (m_mode)
         0: begin
            if ($countones(m_syn) == 1) begin
               m_cand = m_syn; m_cnt = 1; m_mode = 1;
            end else if ($countones(m_syn) > 1) begin
               m_err = 1'b1; m_cnt = 0; m_mode = 3;
            end
         end
         1: begin
            if (m_syn != m_cand) m_mode = 0;
            else begin
               m_cnt++;
               if (m_cnt == DB) begin
                  m_valid = 1'b1; m_code = CW'(idx_of(m_cand)); m_mode = 2; m_cnt = 0;
               end
            end
         end
         2: begin
            if (m_syn != m_cand) begin
               if ((m_syn & m_cand) != '0) m_err = 1'b1;
               m_mode = 3; m_cnt = 0;
            end else begin
`ifdef KEYPAD_REPEAT_EN
               m_cnt++;
               if (m_cnt == RP) begin m_valid = 1'b1; m_cnt = 0; end
`endif
            end
         end
         default: begin
            if (m_syn != '0) m_cnt = 0;
            else begin
               m_cnt++;
               if (m_cnt == DB) m_mode = 0;
            end
         end
      endcase
      m_syn = m_s1;
      m_s1  = b;
   endtask

   task automatic expect_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic m_held;
      m_held = (m_mode == 2);
      checks++;
      if (key_code !== m_code || key_valid !== m_valid || key_held !== m_held ||
          multi_key_err !== m_err) begin
         failures++;
         $display("FAIL %s t=%0t: got code=%0d valid=%0b held=%0b err=%0b, expected code=%0d valid=%0b held=%0b err=%0b",
                  tag, $time, key_code, key_valid, key_held, multi_key_err,
                  m_code, m_valid, m_held, m_err);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (rst) model_reset();
      else model_step(buttons);
      #1;
      if (key_valid === 1'b1) n_valid++;
      if (multi_key_err === 1'b1) n_err++;
      check_model(tag);
   endtask

   initial begin
      int nv0, ne0;
      segs[0]  = '{16'h0008, 10, 1, 0, 4'd3,  1'b1};
      segs[1]  = '{16'h0000, 12, 0, 0, 4'd3,  1'b0};
      segs[2]  = '{16'h0011,  6, 0, 1, 4'd3,  1'b0};
      segs[3]  = '{16'h0000,  4, 0, 0, 4'd3,  1'b0};
      segs[4]  = '{16'h8000, 12, 1, 0, 4'd15, 1'b1};
      segs[5]  = '{16'h0000, 10, 0, 0, 4'd15, 1'b0};
`ifdef KEYPAD_REPEAT_EN
      segs[6]  = '{16'h0004, 40, 5, 0, 4'd2,  1'b1};
`else
      segs[6]  = '{16'h0004, 40, 1, 0, 4'd2,  1'b1};
`endif
      segs[7]  = '{16'h0024, 10, 0, 1, 4'd2,  1'b0};
      segs[8]  = '{16'h0004, 10, 0, 0, 4'd2,  1'b0};
      segs[9]  = '{16'h0000,  3, 0, 0, 4'd2,  1'b0};
      segs[10] = '{16'h0002,  8, 0, 0, 4'd2,  1'b0};
      segs[11] = '{16'h0000,  8, 0, 0, 4'd2,  1'b0};
      segs[12] = '{16'h0100,  8, 1, 0, 4'd8,  1'b1};
      segs[13] = '{16'h0000,  8, 0, 0, 4'd8,  1'b0};

      // Reset with key 9 down, then release reset with the key still pressed.
      model_reset();
      rst = 1'b1;
      buttons = 16'h0200;
      repeat (3) step("reset_hold");
      expect_eq("reset_outputs", int'({key_code, key_valid, key_held, multi_key_err}), 0);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step("after_reset");
         expect_eq($sformatf("rst_key_valid_edge%0d", k), int'(key_valid), (k == 6) ? 1 : 0);
      end
      expect_eq("rst_key_code", int'(key_code), 9);
      buttons = '0;
      repeat (10) step("release1");

      // Bouncing key 3, then held stable.
      nv0 = n_valid;
      for (int c = 0; c < 20; c++) begin
         buttons = ((c % 4) < 2) ? 16'h0008 : 16'h0000;
         step("bounce");
      end
      expect_eq("bounce_no_strobe", n_valid - nv0, 0);
      buttons = 16'h0008;
      for (int k = 1; k <= 6; k++) begin
         step("bounce_settle");
         expect_eq($sformatf("bounce_valid_edge%0d", k), int'(key_valid), (k == 6) ? 1 : 0);
      end
      expect_eq("bounce_code", int'(key_code), 3);
      buttons = '0;
      repeat (10) step("release2");

      // Segment table.
      for (int s = 0; s < 14; s++) begin
         nv0 = n_valid;
         ne0 = n_err;
         buttons = segs[s].btn;
         repeat (segs[s].cyc) step($sformatf("seg%0d", s));
         expect_eq($sformatf("seg%0d_valid_count", s), n_valid - nv0, segs[s].nv);
         expect_eq($sformatf("seg%0d_err_count", s), n_err - ne0, segs[s].ne);
         expect_eq($sformatf("seg%0d_code", s), int'(key_code), int'(segs[s].code));
         expect_eq($sformatf("seg%0d_held", s), int'(key_held), int'(segs[s].held));
      end

      // Reset asserted mid press debounce (count at 2).
      buttons = 16'h0010;
      repeat (4) step("pre_midreset");
      rst = 1'b1;
      model_reset();
      #1;
      expect_eq("midreset_outputs", int'({key_code, key_valid, key_held, multi_key_err}), 0);
      step("midreset_hold");
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step("midreset_restart");
         expect_eq($sformatf("midreset_valid_edge%0d", k), int'(key_valid), (k == 6) ? 1 : 0);
      end
      expect_eq("midreset_code", int'(key_code), 4);
      buttons = '0;
      repeat (10) step("release3");

      // Random runs of none / one / two keys with occasional resets.
      for (int r = 0; r < 300; r++) begin
         int sel, len, a, b;
         sel = $urandom_range(0, 3);
         len = $urandom_range(1, 12);
         a   = $urandom_range(0, NK - 1);
         b   = $urandom_range(0, NK - 1);
         case (sel)
            0:       buttons = '0;
            3:       buttons = (16'h1 << a) | (16'h1 << b);
            default: buttons = 16'h1 << a;
         endcase
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            model_reset();
            #1;
            check_model("rand_async_reset");
            step("rand_reset");
            rst = 1'b0;
         end
         repeat (len) step("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
